// File: rtl/ppfifo_to_image.sv
// ppfifo_to_image: drains 32-bit pixel words from a ppfifo read port and
// regenerates a raster stream (hsync = active pixel, vsync = active frame).
// Raster timing is free-running once started; missing data shows up as
// black pixels flagged with o_underflow rather than as a stall.
module ppfifo_to_image #(
    parameter int H_ACTIVE = 256,
    parameter int H_BLANK  = 85,
    parameter int V_ACTIVE = 240,
    parameter int V_BLANK  = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [2:0]  o_red,
    output logic [2:0]  o_green,
    output logic [1:0]  o_blue,
    output logic        o_frame_finished,
    output logic        o_underflow,
    input  logic        i_rfifo_ready,
    output logic        o_rfifo_activate,
    input  logic [23:0] i_rfifo_size,
    output logic        o_rfifo_strobe,
    input  logic [31:0] i_rfifo_data
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [HW-1:0] h_p0;
    logic [VW-1:0] v_p0;
    logic [23:0]   rd_cnt;

    logic line_act_p0;
    logic active_px_p0;
    logic usable_p0;
    logic acquire;
    logic unused_data;

    // Only the low byte carries the pixel; the upper bits are don't-care.
    assign unused_data = ^i_rfifo_data[31:8];

    assign line_act_p0  = (state == RUN) && (v_p0 < V_ACT_C);
    assign active_px_p0 = line_act_p0 && (h_p0 < H_ACT_C);

    // A word is usable only once activate is registered high and the block
    // still holds words; this also covers a zero-sized block.
    assign usable_p0 = o_rfifo_activate && (rd_cnt < i_rfifo_size);

    // Strobe is combinational so the pop lands on the same edge that
    // captures the word into the colour registers.
    assign o_rfifo_strobe = active_px_p0 && usable_p0;

    // Blocks are taken at frame start or outside active pixels, so a short
    // block never gets topped up by the next line's data mid-line.
    assign acquire = !o_rfifo_activate && i_rfifo_ready &&
                     (((state == IDLE) && i_enable) || ((state == RUN) && !active_px_p0));

    // Raster state and h/v counters; enable is only honoured at frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            h_p0  <= '0;
            v_p0  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h_p0 <= '0;
                    v_p0 <= '0;
                    if (i_enable && (i_rfifo_ready || o_rfifo_activate))
                        state <= RUN;
                end
                default: begin
                    if (h_p0 == H_LAST) begin
                        h_p0 <= '0;
                        if (v_p0 == V_LAST) begin
                            v_p0 <= '0;
                            if (!i_enable)
                                state <= IDLE;
                        end else begin
                            v_p0 <= v_p0 + 1'b1;
                        end
                    end else begin
                        h_p0 <= h_p0 + 1'b1;
                    end
                end
            endcase
        end
    end

    // Block ownership: acquire, count pops, release on exhaustion or line end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rfifo_activate <= 1'b0;
            rd_cnt           <= '0;
        end else if (acquire) begin
            o_rfifo_activate <= 1'b1;
            rd_cnt           <= '0;
        end else if (o_rfifo_activate) begin
            if (o_rfifo_strobe)
                rd_cnt <= rd_cnt + 24'd1;
            if (!usable_p0)
                o_rfifo_activate <= 1'b0;
            else if (o_rfifo_strobe && ((rd_cnt + 24'd1) == i_rfifo_size))
                o_rfifo_activate <= 1'b0;
            else if (active_px_p0 && (h_p0 == H_ACT_LAST))
                o_rfifo_activate <= 1'b0;
        end
    end

    // ---- stage p0 -> p1: registered raster outputs, one cycle behind counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_hsync          <= 1'b0;
            o_vsync          <= 1'b0;
            o_frame_finished <= 1'b0;
            o_underflow      <= 1'b0;
            o_red            <= '0;
            o_green          <= '0;
            o_blue           <= '0;
        end else begin
            o_hsync          <= active_px_p0;
            o_vsync          <= line_act_p0;
            o_frame_finished <= o_vsync && !line_act_p0;
            o_underflow      <= active_px_p0 && !usable_p0;
            if (o_rfifo_strobe) begin
                o_red   <= i_rfifo_data[7:5];
                o_green <= i_rfifo_data[4:2];
                o_blue  <= i_rfifo_data[1:0];
            end else begin
                o_red   <= '0;
                o_green <= '0;
                o_blue  <= '0;
            end
        end
    end

endmodule

// File: doc/ppfifo_to_image.md
Name: ppfifo_to_image

Overview:
- Video-side reader for the NES image path: drains 32-bit pixel words from a ppfifo read port and regenerates a raster stream.
- Output signalling is the same one the image-capture writer consumes:
  - hsync high = active pixel;
  - vsync high = active frame;
  - falling vsync = frame end.
- Used to replay host-supplied frames into the display path, or to loop back frame captures for test.

Parameters:
- H_ACTIVE, 256, active pixels per line.
- H_BLANK, 85, blank cycles per line (line period = H_ACTIVE+H_BLANK).
- V_ACTIVE, 240, active lines per frame.
- V_BLANK, 22, blank lines per frame.

Ports:
- clk  in  1  single clock; ppfifo read side runs on this clock.
- rst  in  1  asynchronous reset, active-low.
- i_enable  in  1  run raster; 0 holds in IDLE.
- o_hsync  out  1  high while a pixel is driven in the active line.
- o_vsync  out  1  high during active lines.
- o_red  out  3  pixel red.
- o_green  out  3  pixel green.
- o_blue  out  2  pixel blue.
- o_frame_finished  out  1  one-cycle pulse on the cycle o_vsync falls.
- o_underflow  out  1  one-cycle pulse per active pixel with no FIFO data.
- i_rfifo_ready  in  1  a filled block is available.
- o_rfifo_activate  out  1  block ownership.
- i_rfifo_size  in  24  word count of the owned block.
- o_rfifo_strobe  out  1  pop one word.
- i_rfifo_data  in  32  current word, first-word-fall-through, valid while activated with words remaining.

Behaviour:
- Reset (rst low, async):
  - state = IDLE; h/v counters = 0; read count = 0.
  - o_rfifo_activate = 0, o_rfifo_strobe = 0.
  - o_hsync, o_vsync, colours, o_frame_finished, o_underflow all 0.
- Reset mid-frame drops activate immediately; the partially read block is abandoned to the ppfifo reset.
- Pixel format: i_rfifo_data[7:5] = red, [4:2] = green, [1:0] = blue; bits [31:8] are ignored.
- States and transitions:
  - IDLE: wait for i_enable=1 AND i_rfifo_ready=1, then go to RUN with h=0, v=0. Frames never start on an empty FIFO.
  - RUN: h counts 0..H_ACTIVE+H_BLANK-1 and wraps; v increments on h wrap; v wraps at V_ACTIVE+V_BLANK-1.
  - Active pixel: h<H_ACTIVE and v<V_ACTIVE.
  - If i_enable=0 at a frame end (v wrap), go to IDLE. Deassertion mid-frame takes effect only at frame end.
- Outputs are registered with 1 cycle latency from the counters:
  - o_hsync = active pixel, o_vsync = (v<V_ACTIVE), both registered.
  - Colours are forced to 0 whenever o_hsync=0.
- Block acquire:
  - When o_rfifo_activate=0 and i_rfifo_ready=1 (in RUN), assert activate and clear the read count.
  - A word is usable from the cycle after activate rises.
- Per active pixel, while activated with read count < i_rfifo_size:
  - drive the data word;
  - pulse o_rfifo_strobe;
  - read count += 1.
- Block release: when read count reaches i_rfifo_size after a strobe, drop activate on the next cycle.
  - Also drop activate at the end of each active line (h = H_ACTIVE-1) if words remain; the remainder is discarded. One block carries at most one line, matching the writer.
- Underflow: an active pixel with no usable word (not activated, acquire in progress, or block exhausted) is driven as 0 with o_underflow=1.
  - Raster timing never stalls.
- Blanking:
  - No strobes.
  - Acquisition is allowed, so the next line's block is owned before h=0.
- Strobe never asserts unless activate=1 and read count < i_rfifo_size.
- i_rfifo_size = 0: release the next cycle and count as exhausted.
- o_frame_finished: registered pulse coincident with the 1→0 transition of o_vsync.

Test Plan:
- Reset and enable with an empty FIFO → all outputs 0 and state stays IDLE. Then one 256-word block is ready → o_hsync goes high within 3 cycles of ready, and pixels match the words in order.
- Full frame, test parameters H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, V_BLANK=2, four 8-word blocks with data = line*16+pixel:
  - 4 hsync bursts of 8 cycles, 12-cycle period;
  - o_vsync high for 48 cycles, low for 24;
  - exactly one o_frame_finished pulse;
  - 0 underflows.
- Short block: size 5 on an 8-pixel line → 5 data pixels, then 3 black pixels with o_underflow pulses. The next line's block is acquired in blanking.
- Long block: size 12 on an 8-pixel line → exactly 8 strobes, activate drops after pixel 7, and the remaining 4 words are not popped.
- FIFO starved mid-frame (no ready for line 2) → line 2 is all zeros with 8 underflow pulses, and vsync/hsync timing is unchanged.
- Drop i_enable mid-frame → the frame completes, then IDLE with outputs 0. Assert rst low asynchronously mid-line → activate and strobe fall immediately without waiting for a clock edge.
